// File: rtl/instr_fetch_if.sv
// Fetch <-> ROM/decode bundle: stall/redirect from decode, sync-read ROM port,
// and the instruction/status outputs handed to decode.
interface instr_fetch_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_dout;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] pc_out;
  logic             instr_valid;
  logic             fetch_err;
  logic [WIDTH-1:0] err_pc;
  logic [31:0]      fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, rom_dout,
    output rom_addr, instr, pc_out, instr_valid, fetch_err, err_pc, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, rom_dout,
    input  rom_addr, instr, pc_out, instr_valid, fetch_err, err_pc, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch initiator for a one-cycle synchronous-read ROM with stall,
// zero-bubble redirect and a sticky fault on misaligned/out-of-range issue.
module instr_fetch #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               ROM_BYTES = 32
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] LAST_WORD = WIDTH'(ROM_BYTES - 4);

  state_t           state, state_n;
  logic [WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [WIDTH-1:0] resp_pc, resp_pc_n;
  logic [WIDTH-1:0] err_pc, err_pc_n;
  logic             resp_valid, resp_valid_n;
  logic             fetch_err, fetch_err_n;
  logic [31:0]      fetch_count, fetch_count_n;
  logic [WIDTH-1:0] addr;
  logic             issue, legal, accept, instr_valid;

  // Re-presenting resp_pc while stalled keeps rom_dout stable next cycle.
  always_comb begin
    addr = fetch_pc;
    if (state == HALT)                   addr = fetch_pc;
    else if (bus.redirect)               addr = bus.redirect_pc;
    else if (bus.stall && resp_valid)    addr = resp_pc;
  end

  assign legal       = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
  assign issue       = (state != HALT) && (bus.redirect || !bus.stall || !resp_valid);
  assign instr_valid = resp_valid && (state == RUN);
  // The word on display at a faulting edge is never handed on, so not counted.
  assign accept      = instr_valid && !bus.stall && !bus.redirect && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= '0;
      resp_valid  <= 1'b0;
      fetch_err   <= 1'b0;
      err_pc      <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      resp_valid  <= resp_valid_n;
      fetch_err   <= fetch_err_n;
      err_pc      <= err_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    resp_valid_n  = resp_valid;
    fetch_err_n   = fetch_err;
    err_pc_n      = err_pc;
    fetch_count_n = fetch_count;
    if (issue) begin
      if (legal) begin
        resp_pc_n    = addr;
        resp_valid_n = 1'b1;
        fetch_pc_n   = addr + WIDTH'(4);
        state_n      = RUN;
      end else begin
        state_n      = HALT;
        fetch_err_n  = 1'b1;
        err_pc_n     = addr;
        resp_valid_n = 1'b0;
      end
    end
    if (accept) fetch_count_n = fetch_count + 32'd1;
  end

  assign bus.rom_addr    = addr;
  assign bus.instr       = bus.rom_dout;
  assign bus.pc_out      = resp_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.fetch_err   = fetch_err;
  assign bus.err_pc      = err_pc;
  assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: free-run to overrun, stall, redirect,
// redirect+stall, illegal redirects and reset mid-stall. ROM word i = 0x13+i.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if #(.WIDTH(32)) bus ();

  instr_fetch #(.WIDTH(32), .RESET_PC(32'h0), .ROM_BYTES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a < 32'd32) return 32'h13 + (a >> 2);
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) bus.rom_dout <= rom_word(bus.rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.rom_dout    = 32'h0;

    // Reset state
    tick();
    tick();
    check("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("rst_err",   {31'b0, bus.fetch_err},   32'd0);
    check("rst_errpc", bus.err_pc,               32'd0);
    check("rst_count", bus.fetch_count,          32'd0);
    check("rst_addr",  bus.rom_addr,             32'd0);
    rst = 1'b0;

    // Free run to sequential overrun
    tick();
    check("run_valid0", {31'b0, bus.instr_valid}, 32'd1);
    check("run_pc0",    bus.pc_out,               32'd0);
    check("run_instr0", bus.instr,                32'h13);
    for (int k = 1; k < 8; k++) begin
      tick();
      check("run_pc",    bus.pc_out,      32'(4 * k));
      check("run_instr", bus.instr,       32'(32'h13 + k));
      check("run_count", bus.fetch_count, 32'(k));
    end
    tick();
    check("ovr_err",   {31'b0, bus.fetch_err},   32'd1);
    check("ovr_errpc", bus.err_pc,               32'd32);
    check("ovr_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("ovr_count", bus.fetch_count,          32'd7);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    #1;
    check("halt_addr", bus.rom_addr, 32'd32);
    tick();
    bus.redirect = 1'b0;
    check("halt_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("halt_errpc", bus.err_pc,               32'd32);
    check("halt_count", bus.fetch_count,          32'd7);

    // Stall at pc 8
    do_reset();
    tick();
    tick();
    tick();
    check("pre_stall_pc", bus.pc_out, 32'd8);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_addr", bus.rom_addr, 32'd8);
      tick();
      check("stall_pc",    bus.pc_out,               32'd8);
      check("stall_instr", bus.instr,                32'h15);
      check("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
      check("stall_count", bus.fetch_count,          32'd2);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_pc",    bus.pc_out,      32'd12);
    check("unstall_count", bus.fetch_count, 32'd3);

    // Reset mid-stall at pc 16
    tick();
    check("pre_rst_pc", bus.pc_out, 32'd16);
    bus.stall = 1'b1;
    tick();
    check("held_pc", bus.pc_out, 32'd16);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("mid_rst_err",   {31'b0, bus.fetch_err},   32'd0);
    check("mid_rst_count", bus.fetch_count,          32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("boot_stall_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("boot_stall_pc",    bus.pc_out,               32'd0);
    bus.stall = 1'b0;

    // Redirect from pc 4 to 20
    tick();
    check("pre_redir_pc", bus.pc_out, 32'd4);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'd20;
    #1;
    check("redir_addr", bus.rom_addr, 32'd20);
    tick();
    bus.redirect = 1'b0;
    check("redir_pc",    bus.pc_out,      32'd20);
    check("redir_instr", bus.instr,       32'h18);
    check("redir_count", bus.fetch_count, 32'd1);
    tick();
    check("post_redir_pc",    bus.pc_out,      32'd24);
    check("post_redir_count", bus.fetch_count, 32'd2);

    // Redirect and stall together
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'd20;
    tick();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    check("rs_pc",    bus.pc_out,      32'd20);
    check("rs_count", bus.fetch_count, 32'd2);
    tick();
    check("rs_next_pc", bus.pc_out,      32'd24);
    check("rs_count2",  bus.fetch_count, 32'd3);

    // Misaligned redirect, then ignored redirect to 0
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h6;
    tick();
    check("mis_err",   {31'b0, bus.fetch_err},   32'd1);
    check("mis_errpc", bus.err_pc,               32'h6);
    check("mis_valid", {31'b0, bus.instr_valid}, 32'd0);
    check("mis_count", bus.fetch_count,          32'd3);
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    check("mis_hold_errpc", bus.err_pc,               32'h6);
    check("mis_hold_valid", {31'b0, bus.instr_valid}, 32'd0);

    // Out-of-range redirect
    do_reset();
    tick();
    check("oor_pre_pc", bus.pc_out, 32'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    tick();
    check("oor_err",   {31'b0, bus.fetch_err},   32'd1);
    check("oor_errpc", bus.err_pc,               32'h40);
    check("oor_valid", {31'b0, bus.instr_valid}, 32'd0);
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    check("oor_hold_errpc", bus.err_pc,               32'h40);
    check("oor_hold_valid", {31'b0, bus.instr_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
